captura_indexada: RTL and testbench
===================================

Name: captura_indexada

Overview:
- Downstream consumer of the 5-bit index counter (selec_contador).
- Uses the counter's index output and a serial data bit to assemble a 32-bit word, one bit per CE tick, at bit position = index.
- Presents the finished word with a valid/ack handshake.
- Reports sequence errors and overruns.
- Sits between the counter and the word-level logic; CLK and CE are shared with the counter.

Parameters:
IDX_W, 5, index width; must match the counter width
NBITS, 32, word width; fixed at 2**IDX_W

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset; 0 clears all state immediately
CE  in  1  clock-enable tick, the same signal that drives the counter
start  in  1  frame start request, sampled only when CE=1
idx  in  IDX_W  current index from the counter (cnt2)
din  in  1  serial data bit belonging to idx
ack  in  1  consumer acknowledge of word
word  out  NBITS  captured word, stable while word_valid=1
word_valid  out  1  word available; held high until ack
busy  out  1  high in CAPTURE
seq_err  out  1  sticky: idx broke the 0..NBITS-1 sequence
overrun  out  1  sticky: start requested while a word was still unacknowledged

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RESET).
- Reset values: state=IDLE, exp_idx=0, shadow=0, word=0, word_valid=0, busy=0, seq_err=0, overrun=0.
- FSM states: IDLE, CAPTURE, HOLD. The state register and every output are registered.
- IDLE:
  - CE=1 and start=1 -> CAPTURE next cycle.
  - On entry to CAPTURE: exp_idx<=0, shadow<=0, seq_err<=0, overrun<=0.
- CAPTURE (busy=1), acting on CE=1 only:
  - idx==exp_idx: shadow[idx]<=din, exp_idx<=exp_idx+1.
  - idx!=exp_idx: seq_err<=1, go to IDLE, word unchanged, word_valid stays 0.
  - idx==NBITS-1 and matches: word<=shadow with bit NBITS-1 replaced by din, word_valid<=1, go to HOLD.
  - word_valid is visible the cycle after the CE edge that captured index 31 (latency 1).
  - exp_idx wraps 31->0 on completion; no carry out.
  - start during CAPTURE is ignored (no restart).
  - CE=0: no change.
- HOLD (word_valid=1, word frozen):
  - ack=1 (honoured regardless of CE): word_valid<=0, go to IDLE. word keeps its last value.
  - CE=1 and start=1 with ack=0: overrun<=1; start is dropped and the state stays HOLD.
  - CE=1, start=1 and ack=1 in the same cycle: ack wins, overrun is not set, start is dropped. A new frame needs start on a later CE tick.
- ack outside HOLD: ignored.
- Reset mid-frame: immediate return to reset values; a partial shadow is discarded.
- Sticky flags clear only on reset or on the next accepted start.
- No combinational path from any input to any output.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, CAPTURE=2'd1, HOLD=2'd2), IDX_W and NBITS defaults.
- One natural sub-module: idx_checker, an expected-index register with compare/increment. It outputs match and last (exp_idx==NBITS-1).
- Word and flag registers stay in the top module.

Test Plan:
- Reset: RESET=0 asynchronously mid-cycle -> all outputs 0 before the next CLK edge; state IDLE.
- Nominal frame: start on a CE tick, then idx 0..31 on successive CE ticks with din=idx[0] -> word=32'hAAAAAAAA, word_valid=1 one cycle after idx=31; hold until ack, then word_valid=0 the next cycle.
- CE gating: CE=1 every 3rd cycle, din pattern 32'h1234_5678 -> identical word, captured only on CE cycles, busy=1 throughout.
- Sequence error: idx 0,1,2,5 -> seq_err=1 after idx=5, state IDLE, word_valid=0, word keeps its previous value.
- Overrun and simultaneous events: in HOLD, start with ack=0 -> overrun=1 and word unchanged. Then start with ack=1 in the same cycle -> word_valid=0, overrun stays 1, no new frame. The next start clears overrun.
- Reset mid-frame: RESET=0 after idx=15 -> word=0, busy=0. A new frame then completes correctly.

Source files
------------

// File: rtl/captura_indexada_pkg.sv
// Shared definitions for the indexed serial-to-word capture block.
package captura_indexada_pkg;

    localparam int IDX_W_DEF = 5;
    localparam int NBITS_DEF = 1 << IDX_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/captura_indexada_idx_checker.sv
// Expected-index tracker: holds the next index a frame must see,
// compares it against the counter and flags the final bit position.
module captura_indexada_idx_checker #(
    parameter int IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             match_o,
    output logic             last_o
);

    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;

    // Clear on frame start, step on every accepted bit; the increment
    // wraps from all-ones back to zero when a frame completes.
    always_comb begin
        exp_idx_d = exp_idx_q;
        if (clr_i)
            exp_idx_d = '0;
        else if (adv_i)
            exp_idx_d = exp_idx_q + 1'b1;
    end

    // Expected-index register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            exp_idx_q <= '0;
        else
            exp_idx_q <= exp_idx_d;
    end

    assign match_o = (idx_i == exp_idx_q);
    assign last_o  = (exp_idx_q == {IDX_W{1'b1}});

endmodule

// File: rtl/captura_indexada.sv
// Assembles a word one bit per CE tick at the position given by the
// index counter, then presents it with a valid/ack handshake. Flags
// broken index sequences and starts that arrive while a word is pending.
module captura_indexada
    import captura_indexada_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int NBITS = 1 << IDX_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             start,
    input  logic [IDX_W-1:0] idx,
    input  logic             din,
    input  logic             ack,
    output logic [NBITS-1:0] word,
    output logic             word_valid,
    output logic             busy,
    output logic             seq_err,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic [NBITS-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             seq_err_q, seq_err_d;
    logic             overrun_q, overrun_d;
    logic             clr, adv, match, last;

    captura_indexada_idx_checker #(.IDX_W(IDX_W)) u_idx_checker (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr_i   (clr),
        .adv_i   (adv),
        .idx_i   (idx),
        .match_o (match),
        .last_o  (last)
    );

    // Next-state and register updates; everything holds unless acted on.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        word_d    = word_q;
        valid_d   = valid_q;
        seq_err_d = seq_err_q;
        overrun_d = overrun_q;
        clr       = 1'b0;
        adv       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CE && start) begin
                    state_d   = ST_CAPTURE;
                    clr       = 1'b1;
                    shadow_d  = '0;
                    seq_err_d = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                // start is ignored here: a frame never restarts itself.
                if (CE) begin
                    if (match) begin
                        shadow_d[idx] = din;
                        adv           = 1'b1;
                        if (last) begin
                            // Last bit goes straight into the word so valid
                            // appears one cycle after the final CE edge.
                            word_d          = shadow_q;
                            word_d[NBITS-1] = din;
                            valid_d         = 1'b1;
                            state_d         = ST_HOLD;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // ack wins over a simultaneous start; the start is dropped.
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (CE && start) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CAPTURE);
    end

    // State, data and flag registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            seq_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            seq_err_q <= seq_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign seq_err    = seq_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_captura_indexada.sv
// Bench for captura_indexada: constant vector table, directed frame
// sequences and a randomized run against a frame-level reference model.
module tb_captura_indexada;

    logic        CLK;
    logic        RESET;
    logic        CE;
    logic        start;
    logic [4:0]  idx;
    logic        din;
    logic        ack;
    logic [31:0] word;
    logic        word_valid;
    logic        busy;
    logic        seq_err;
    logic        overrun;

    captura_indexada dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CE         (CE),
        .start      (start),
        .idx        (idx),
        .din        (din),
        .ack        (ack),
        .word       (word),
        .word_valid (word_valid),
        .busy       (busy),
        .seq_err    (seq_err),
        .overrun    (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame mode (0 idle, 1 capturing, 2 holding).
    int          m_mode;
    int          m_exp;
    logic [31:0] m_shadow;
    logic [31:0] m_word;
    logic        m_valid, m_seq, m_ovr;

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_shadow = '0; m_word = '0;
        m_valid = 0; m_seq = 0; m_ovr = 0;
    endtask

    task automatic model_step(input logic ce, st, input logic [4:0] ix,
                              input logic d, a);
        if (m_mode == 0) begin
            if (ce && st) begin
                m_mode = 1; m_exp = 0; m_shadow = '0; m_seq = 0; m_ovr = 0;
            end
        end else if (m_mode == 1) begin
            if (ce) begin
                if (int'(ix) == m_exp) begin
                    m_shadow[ix] = d;
                    if (m_exp == 31) begin
                        m_word = m_shadow; m_valid = 1; m_mode = 2; m_exp = 0;
                    end else begin
                        m_exp = m_exp + 1;
                    end
                end else begin
                    m_seq = 1; m_mode = 0;
                end
            end
        end else begin
            if (a) begin
                m_valid = 0; m_mode = 0;
            end else if (ce && st) begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic ce, st, input logic [4:0] ix, input logic d, a);
        CE = ce; start = st; idx = ix; din = d; ack = a;
        @(posedge CLK); #1;
        model_step(ce, st, ix, d, a);
        chk("cycle", {word, word_valid, busy, seq_err, overrun},
                     {m_word, m_valid, m_mode == 1, m_seq, m_ovr});
    endtask

    // Start then feed idx 0..last; CE asserted every ce_per cycles.
    task automatic frame(input logic [31:0] data, input int last, input int ce_per);
        apply(1, 1, 0, 0, 0);
        for (int i = 0; i <= last; i++) begin
            for (int k = 1; k < ce_per; k++) begin
                apply(0, 0, 5'(i), 1'($urandom), 0);
                chk("ce_busy", busy, 1);
            end
            apply(1, 0, 5'(i), data[i], 0);
        end
    endtask

    typedef struct {
        logic       ce, st;
        logic [4:0] ix;
        logic       d, a;
        logic       ev, eb, es, eo;
    } vec_t;

    function automatic vec_t mk(input logic ce, st, input logic [4:0] ix,
                                input logic d, a, ev, eb, es, eo);
        vec_t v;
        v.ce = ce; v.st = st; v.ix = ix; v.d = d; v.a = a;
        v.ev = ev; v.eb = eb; v.es = es; v.eo = eo;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        logic [31:0] rdata;
        logic [4:0]  rix;

        tbl[0] = mk(1, 1, 0, 0, 0, 0, 1, 0, 0); // start
        tbl[1] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0); // idx 0
        tbl[2] = mk(0, 0, 5, 0, 0, 0, 1, 0, 0); // CE low: no effect
        tbl[3] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0); // idx 1
        tbl[4] = mk(1, 1, 2, 1, 0, 0, 1, 0, 0); // start ignored in capture
        tbl[5] = mk(1, 0, 5, 0, 0, 0, 0, 1, 0); // idx jump -> seq_err
        tbl[6] = mk(1, 0, 0, 0, 1, 0, 0, 1, 0); // ack in idle ignored
        tbl[7] = mk(1, 1, 0, 0, 0, 0, 1, 0, 0); // new start clears seq_err
        tbl[8] = mk(1, 0, 7, 0, 0, 0, 0, 1, 0); // wrong first idx

        CE = 0; start = 0; idx = 0; din = 0; ack = 0;
        RESET = 0;
        model_reset();
        #23;
        chk("reset_outs", {word, word_valid, busy, seq_err, overrun}, 36'h0);
        RESET = 1;
        @(posedge CLK); #1;

        foreach (tbl[i]) begin
            apply(tbl[i].ce, tbl[i].st, tbl[i].ix, tbl[i].d, tbl[i].a);
            chk($sformatf("tbl%0d", i), {word, word_valid, busy, seq_err, overrun},
                {32'h0, tbl[i].ev, tbl[i].eb, tbl[i].es, tbl[i].eo});
        end

        // Nominal frame, din = idx[0].
        frame(32'hAAAA_AAAA, 31, 1);
        chk("nom_word", word, 32'hAAAA_AAAA);
        chk("nom_valid", word_valid, 1);
        for (int k = 0; k < 3; k++) apply(k[0], 0, 0, 0, 0);
        chk("hold_valid", word_valid, 1);
        apply(0, 0, 0, 0, 1);
        chk("ack_valid", word_valid, 0);
        chk("ack_word", word, 32'hAAAA_AAAA);

        // CE every third cycle.
        frame(32'h1234_5678, 31, 3);
        chk("gate_word", word, 32'h1234_5678);
        apply(1, 0, 0, 0, 1);

        // Sequence error: 0,1,2,5.
        apply(1, 1, 0, 0, 0);
        apply(1, 0, 0, 1, 0);
        apply(1, 0, 1, 1, 0);
        apply(1, 0, 2, 1, 0);
        apply(1, 0, 5, 1, 0);
        chk("seq_err", seq_err, 1);
        chk("seq_busy", busy, 0);
        chk("seq_valid", word_valid, 0);
        chk("seq_word", word, 32'h1234_5678);

        // Overrun and simultaneous start/ack.
        frame(32'hCAFE_F00D, 31, 1);
        apply(1, 1, 0, 0, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_word", word, 32'hCAFE_F00D);
        chk("ovr_valid", word_valid, 1);
        apply(1, 1, 0, 0, 1);
        chk("sim_valid", word_valid, 0);
        chk("sim_ovr", overrun, 1);
        chk("sim_busy", busy, 0);
        apply(1, 0, 0, 0, 0);
        chk("sim_nostart", busy, 0);
        apply(1, 1, 0, 0, 0);
        chk("ovr_clr", overrun, 0);
        chk("restart_busy", busy, 1);
        apply(1, 0, 9, 0, 0);

        // Reset mid-frame after idx 15.
        frame(32'hFFFF_FFFF, 15, 1);
        #2 RESET = 0;
        #1;
        model_reset();
        chk("async_rst", {word, word_valid, busy, seq_err, overrun}, 36'h0);
        @(posedge CLK); #1;
        RESET = 1;
        frame(32'h0F0F_3C3C, 31, 1);
        chk("post_rst_word", word, 32'h0F0F_3C3C);
        apply(0, 0, 0, 0, 1);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            rdata = $urandom;
            rix = ($urandom_range(0, 24) == 0) ? 5'($urandom) : 5'(m_exp);
            apply(rdata[0], rdata[3:1] == 3'd0, rix, rdata[4],
                  rdata[7:5] == 3'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
